// File: rtl/sync_fifo.sv
// sync_fifo - single-clock FIFO with registered read data.
//
// The producer writes din when wr_en is high and the FIFO is not full.
// The consumer requests the oldest entry with rd_en when the FIFO is not
// empty; that entry appears on dout one cycle later and stays there
// until the next accepted read. Requests that cannot be honoured
// (write when full, read when empty) are ignored.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-low reset (clears pointers, count, dout)
//   wr_en  in   write request
//   rd_en  in   read request
//   din    in   write data   [DATA_WIDTH-1:0]
//   dout   out  registered read data [DATA_WIDTH-1:0]
//   full   out  FIFO holds DEPTH entries
//   empty  out  FIFO holds no entries
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] C_FULL = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_dout;

  logic w_wr_acc;
  logic w_rd_acc;

  // Flags decode the registered count, so they never glitch.
  assign full     = (r_count == C_FULL);
  assign empty    = (r_count == '0);
  assign w_wr_acc = wr_en & ~full;
  assign w_rd_acc = rd_en & ~empty;
  assign dout     = r_dout;

  // Storage is deliberately left out of reset; stale contents are never
  // visible because reads are gated by the count.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
        r_dout   <= r_mem[r_rd_ptr];
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + (ADDR_WIDTH + 1)'(1);
        2'b01:   r_count <= r_count - (ADDR_WIDTH + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Simulation-time sanity properties; ignored by synthesis.
  a_flags_exclusive : assert property (@(posedge clk) disable iff (!rst)
    !(full && empty));

  a_count_bound : assert property (@(posedge clk) disable iff (!rst)
    r_count <= C_FULL);

  a_write_when_full : assert property (@(posedge clk) disable iff (!rst)
    (wr_en && full && !rd_en) |=> (r_count == $past(r_count)));

  a_read_when_empty : assert property (@(posedge clk) disable iff (!rst)
    (rd_en && empty) |=> $stable(r_dout));

  a_write_clears_empty : assert property (@(posedge clk) disable iff (!rst)
    (w_wr_acc && !w_rd_acc) |=> !empty);

  a_read_clears_full : assert property (@(posedge clk) disable iff (!rst)
    (w_rd_acc && !w_wr_acc) |=> !full);

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo - randomized and directed scoreboard bench for sync_fifo.
// The driver updates a queue-based model of the FIFO and records the
// expected dout/full/empty for the state after each clock edge; a
// separate monitor compares those records against the DUT.
module tb_sync_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          full;
  logic          empty;

  sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [DW-1:0] d;
    logic          f;
    logic          e;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_dout;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, req, cyc, $time);
    end
  endtask

  // Monitor: compare every record whose edge has already happened.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        chk("dout",  {24'd0, dout},  {24'd0, e.d});
        chk("full",  {31'd0, full},  {31'd0, e.f});
        chk("empty", {31'd0, empty}, {31'd0, e.e});
      end
    end
  end

  function automatic void push_exp();
    exp_t e;
    e.cyc = cyc + 1;
    e.d   = m_dout;
    e.f   = (m_q.size() == DEPTH);
    e.e   = (m_q.size() == 0);
    exp_q.push_back(e);
  endfunction

  // Called just after a rising edge: drive inputs for the next edge,
  // advance the model, record the expectation, then wait for that edge.
  task automatic step(input logic we, input logic re, input logic [DW-1:0] d);
    bit wa, ra;
    rst   = 1'b1;
    wr_en = we;
    rd_en = re;
    din   = d;
    wa = we && (m_q.size() < DEPTH);
    ra = re && (m_q.size() > 0);
    if (ra) m_dout = m_q.pop_front();
    if (wa) m_q.push_back(d);
    push_exp();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_step();
    rst   = 1'b0;
    wr_en = 1'($urandom);
    rd_en = 1'($urandom);
    din   = DW'($urandom);
    m_q.delete();
    m_dout = '0;
    push_exp();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pw, pr;
    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    m_dout = '0;

    // Reset asserted asynchronously, before any clock edge.
    #2 rst = 1'b0;
    #1;
    chk("rst_async_dout",  {24'd0, dout},  32'h0);
    chk("rst_async_empty", {31'd0, empty}, 32'h1);
    chk("rst_async_full",  {31'd0, full},  32'h0);
    @(posedge clk);
    #1;
    reset_step();
    reset_step();
    step(1'b0, 1'b0, 8'h00);

    // Fill, overflow attempt, drain, underflow attempts.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(i));
    step(1'b1, 1'b0, 8'hAA);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00);

    // Simultaneous read/write at empty, mid-level and full.
    step(1'b1, 1'b1, 8'h55);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, DW'(8'h56 + i));
    step(1'b1, 1'b1, 8'h60);
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, DW'(8'h61 + i));
    step(1'b1, 1'b1, 8'h99);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00);

    // Pointer wrap-around.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, DW'(8'h10 + i));
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(8'h20 + i));
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00);

    // Asynchronous reset between edges with 7 entries stored.
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, DW'(8'h40 + i));
    wr_en = 1'b0;
    rd_en = 1'b0;
    #3 rst = 1'b0;
    #1;
    chk("rst_mid_dout",  {24'd0, dout},  32'h0);
    chk("rst_mid_empty", {31'd0, empty}, 32'h1);
    chk("rst_mid_full",  {31'd0, full},  32'h0);
    m_q.delete();
    m_dout = '0;
    push_exp();
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 8'h77);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    // Randomized traffic with shifting write/read bias.
    for (int i = 0; i < 1500; i++) begin
      case ((i / 100) % 3)
        0:       begin pw = 80; pr = 30; end
        1:       begin pw = 25; pr = 80; end
        default: begin pw = 60; pr = 60; end
      endcase
      step($urandom_range(99) < pw, $urandom_range(99) < pr, DW'($urandom));
    end

    #2;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock synchronous FIFO buffer with registered read data and full/empty status flags.
- Decouples a producer and a consumer in the same clock domain.
- Sits between a write-side data source and a read-side sink; a verification environment drives it through a shared interface bundle (intf).

Parameters:
- DATA_WIDTH, 8, width of din/dout in bits.
- DEPTH, 16, number of storage entries; must be a power of two and at least 2.
- ADDR_WIDTH, log2(DEPTH) = 4, pointer width (derived, not user-set).

Ports:
- clk    input   1           rising-edge clock.
- rst    input   1           asynchronous active-low reset.
- wr_en  input   1           write request; din is captured when accepted.
- rd_en  input   1           read request; oldest entry is moved to dout when accepted.
- din    input   DATA_WIDTH  write data.
- dout   output  DATA_WIDTH  registered read data.
- full   output  1           FIFO holds DEPTH entries.
- empty  output  1           FIFO holds 0 entries.

Behaviour:
- Reset: asserting rst low immediately (asynchronously) clears state.
  - Write pointer, read pointer and occupancy count go to 0.
  - dout goes to 0, empty goes to 1, full goes to 0.
  - Memory contents are not cleared and not observable.
- Reset release is synchronous to clk; the first accepted operation is on the first rising edge with rst high.
- Reset mid-operation discards all stored data; the FIFO restarts empty.
- Write accepted when wr_en=1 and full=0 at the rising edge.
  - din is stored at the write pointer.
  - Write pointer increments modulo DEPTH.
- Write with full=1 is dropped: no state change, no data corruption.
- Read accepted when rd_en=1 and empty=0 at the rising edge.
  - mem[read pointer] is loaded into dout, so read latency is 1 cycle: data is valid after the edge that accepted the read.
  - Read pointer increments modulo DEPTH.
- Read with empty=1 is dropped: dout holds its previous value, no pointer change.
- dout holds its value whenever no read is accepted.
- Occupancy count (ADDR_WIDTH+1 bits) updates per edge:
  - +1 on a write-only accept.
  - -1 on a read-only accept.
  - Unchanged when both or neither are accepted.
- Flags: full = (count == DEPTH) and empty = (count == 0). Both are combinational decodes of registered count, so they are glitch-free and update in the same cycle as the count.
- Simultaneous wr_en and rd_en:
  - Neither full nor empty: both are accepted; count is unchanged; dout gets the oldest entry.
  - full=1: read is accepted, write is dropped; count becomes DEPTH-1.
  - empty=1: write is accepted, read is dropped; count becomes 1; dout is unchanged.
- Both pointers wrap from DEPTH-1 to 0 with no loss of ordering. Strict first-in-first-out order is preserved across wrap.
- full and empty are never both 1.
- Embedded assertions (simulation only, disabled during reset):
  - Not (full and empty).
  - count never exceeds DEPTH.
  - A write attempt while full leaves count unchanged.
  - A read attempt while empty leaves dout unchanged.
  - After an accepted write-only, empty is 0 next cycle.
  - After an accepted read-only, full is 0 next cycle.

Test Plan:
- Reset: hold rst=0 for 2 cycles with random wr_en/rd_en/din -> dout=0x00, empty=1, full=0 throughout; release, idle 1 cycle -> flags unchanged.
- Fill/drain: write 0x00..0x0F (16 writes) -> full=1 after the 16th edge, empty=0. Then read 16 times -> dout sequence 0x00..0x0F, each one cycle after its read edge; empty=1 after the 16th read.
- Overflow/underflow: when full, write 0xAA -> dropped, and a later drain never shows 0xAA. When empty, rd_en=1 for 3 cycles -> dout holds its last value (0x0F), empty stays 1.
- Simultaneous ops:
  - Empty, wr_en=rd_en=1, din=0x55 -> empty=0, dout unchanged.
  - 5 entries, both asserted -> count stays 5, dout=oldest.
  - Full, both asserted -> full=0, oldest entry on dout.
- Wrap-around: write 10, read 10, write 16 values 0x20..0x2F -> read back 0x20..0x2F in order, full/empty correct at each boundary.
- Async reset mid-stream: with 7 entries, pull rst low between clock edges -> empty=1, full=0, dout=0 immediately. After release, write 0x77 then read -> dout=0x77.
